timer_ctrl_fsm: RTL and testbench
=================================

TIMER_CTRL_FSM -- requirements
Module: timer_ctrl_fsm

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, range 1..255: consecutive synchronized-high cycles needed to accept a button press.
REQ-002 SHALL have parameter CLEAR_CYCLES, default 2, range 1..15: cycles timer_clear is held in CLEAR.
REQ-003 SHALL have port sys_clk  input  1  single system clock; all flops on rising edge.
REQ-004 SHALL have port int_reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port btn_start_stop  input  1  asynchronous raw start/stop button, active-high.
REQ-006 SHALL have port btn_clear  input  1  asynchronous raw clear button, active-high.
REQ-007 SHALL have port timer_max_reached  input  1  synchronous level from the counter chain; high when the display is at its maximum value.
REQ-008 SHALL have port timer_pause  output  1  hold request to every timer_clk_counter stage.
REQ-009 SHALL have port timer_clear  output  1  zero request to every counter stage.
REQ-010 SHALL have port timer_running  output  1  high only in RUN.
REQ-011 SHALL have port ctrl_state  output  3  current state code.

Function
REQ-012 SHALL pass each button through its own 2-flop synchronizer before any other use.
REQ-013 SHALL run one debounce counter per button: increment while the synchronized level is high, saturating at DEBOUNCE_CYCLES; reset to 0 in any cycle the synchronized level is low.
REQ-014 SHALL emit one internal press pulse, one cycle wide, in the cycle the counter reaches DEBOUNCE_CYCLES; no further pulse until the synchronized level has been low at least one cycle.
REQ-015 SHALL implement states IDLE=0, RUN=1, PAUSED=2, CLEAR=3, DONE=4; codes 5-7 SHALL go to IDLE on the next edge.
REQ-016 SHALL decode outputs from the registered state only (Moore):
- IDLE: pause=1, clear=0
- RUN: pause=0, clear=0
- PAUSED: pause=1, clear=0
- CLEAR: pause=0, clear=1
- DONE: pause=1, clear=0
REQ-017 SHALL never drive timer_pause and timer_clear high together, because downstream counters give pause priority over clear.
REQ-018 SHALL take these transitions on a start/stop pulse: IDLE->RUN, RUN->PAUSED, PAUSED->RUN; ignore the pulse in CLEAR and DONE.
REQ-019 SHALL go from RUN to DONE when timer_max_reached is high.
REQ-020 SHALL go to CLEAR on a clear pulse from IDLE, RUN, PAUSED or DONE; a clear pulse while in CLEAR SHALL be ignored and SHALL NOT restart the hold.
REQ-021 SHALL stay in CLEAR exactly CLEAR_CYCLES cycles, then go to IDLE; a 4-bit hold counter loads 0 on CLEAR entry.
REQ-022 SHALL apply this priority when events coincide: clear pulse > timer_max_reached (RUN only) > start/stop pulse.
REQ-023 SHALL make the total latency from the first rising edge sampling btn_start_stop high (held high) to the changed timer_pause value exactly DEBOUNCE_CYCLES+3 edges.
REQ-024 SHALL ignore timer_max_reached in every state except RUN.

Reset
REQ-025 SHALL, while int_reset is high at a rising edge:
- clear synchronizer flops, debounce counters and hold counter to 0
- re-arm both press detectors
- set state to IDLE
REQ-026 SHALL make outputs after reset: timer_pause=1, timer_clear=0, timer_running=0, ctrl_state=0.
REQ-027 SHALL abort any operation when reset is asserted mid-operation (RUN, PAUSED, CLEAR mid-hold, or mid-debounce), with no press pulse emitted for a button already held when reset releases until it is low at least one cycle.

Verification
REQ-028 SHALL cover start: D=4, IDLE, btn_start_stop high and held -> timer_pause 1->0 exactly 7 edges after first sample, ctrl_state=1, timer_running=1; holding longer causes no second transition.
REQ-029 SHALL cover bounce rejection: btn_clear high 3 cycles, low 1 cycle, repeated 5 times -> no state change.
REQ-030 SHALL cover pause/resume: RUN, press start/stop -> PAUSED (pause=1); press again -> RUN (pause=0).
REQ-031 SHALL cover clear: CLEAR_CYCLES=2, press clear from PAUSED -> timer_clear=1, timer_pause=0 for exactly 2 cycles, then IDLE; a second clear pulse during the hold does not extend it.
REQ-032 SHALL cover coincidence: in RUN, start/stop pulse and timer_max_reached high in the same cycle -> DONE; in DONE, start/stop ignored; clear -> CLEAR -> IDLE.
REQ-033 SHALL cover reset mid-CLEAR: int_reset for 1 cycle -> IDLE, pause=1, clear=0 on the next cycle; a held button produces no pulse until released and pressed again.

Source files
------------

// File: rtl/timer_ctrl_if.sv
// Button, counter-status and control signals exchanged between the
// stopwatch front panel / counter chain and the timer control FSM.
interface timer_ctrl_if;
  logic       btn_start_stop;
  logic       btn_clear;
  logic       timer_max_reached;
  logic       timer_pause;
  logic       timer_clear;
  logic       timer_running;
  logic [2:0] ctrl_state;

  modport master (
    output btn_start_stop,
    output btn_clear,
    output timer_max_reached,
    input  timer_pause,
    input  timer_clear,
    input  timer_running,
    input  ctrl_state
  );

  modport slave (
    input  btn_start_stop,
    input  btn_clear,
    input  timer_max_reached,
    output timer_pause,
    output timer_clear,
    output timer_running,
    output ctrl_state
  );
endinterface

// File: rtl/timer_ctrl_fsm.sv
// Stopwatch control FSM: synchronizes and debounces the start/stop and clear
// buttons, then drives Moore-decoded pause/clear requests to the counter chain.
module timer_ctrl_fsm #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CLEAR_CYCLES    = 2
) (
  input  logic        sys_clk,
  input  logic        int_reset,
  timer_ctrl_if.slave bus
);

  localparam int unsigned NUM_BTN = 2;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned HOLD_W  = 4;
  localparam logic [CNT_W-1:0]  DEB_MAX   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CLEAR_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    PAUSED = 3'd2,
    CLEAR  = 3'd3,
    DONE   = 3'd4
  } state_t;

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] press;
  logic [1:0]         prime;
  logic               ss_pulse;
  logic               clr_pulse;

  state_t             state;
  state_t             state_nxt;
  logic [HOLD_W-1:0]  hold;
  logic [HOLD_W-1:0]  hold_nxt;
  logic               pause_q;
  logic               clear_q;
  logic               run_q;
  logic [2:0]         code_q;

  assign raw = {bus.btn_clear, bus.btn_start_stop};

  // Two-flop synchronizers; prime marks when sync2 again reflects a real sample
  always_ff @(posedge sys_clk) begin
    if (int_reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prime <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      prime <= {prime[0], 1'b1};
    end
  end

  // Per-button saturating debounce counter and one-shot press detector.
  // Reset leaves the detector waiting for a genuine low, so a button held
  // through reset cannot fire until it has been released.
  for (genvar g = 0; g < int'(NUM_BTN); g++) begin : g_btn
    logic [CNT_W-1:0] cnt;
    logic             armed;

    assign press[g] = armed && (cnt == DEB_MAX);

    always_ff @(posedge sys_clk) begin
      if (int_reset) begin
        cnt   <= '0;
        armed <= 1'b0;
      end else if (!sync2[g]) begin
        cnt   <= '0;
        armed <= armed | prime[1];
      end else begin
        if (cnt != DEB_MAX) begin
          cnt <= cnt + 1'b1;
        end
        if (press[g]) begin
          armed <= 1'b0;
        end
      end
    end
  end

  assign ss_pulse  = press[0];
  assign clr_pulse = press[1];

  // Next state: clear pulse > max reached (RUN only) > start/stop pulse
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    case (state)
      IDLE: begin
        if (ss_pulse) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.timer_max_reached) begin
          state_nxt = DONE;
        end else if (ss_pulse) begin
          state_nxt = PAUSED;
        end
      end
      PAUSED: begin
        if (ss_pulse) begin
          state_nxt = RUN;
        end
      end
      CLEAR: begin
        if (hold == HOLD_LAST) begin
          state_nxt = IDLE;
        end else begin
          hold_nxt = hold + 1'b1;
        end
      end
      DONE: begin
        state_nxt = DONE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (clr_pulse && (state inside {IDLE, RUN, PAUSED, DONE})) begin
      state_nxt = CLEAR;
      hold_nxt  = '0;
    end
  end

  // State register; outputs registered from the next state so they track it
  always_ff @(posedge sys_clk) begin
    if (int_reset) begin
      state   <= IDLE;
      hold    <= '0;
      pause_q <= 1'b1;
      clear_q <= 1'b0;
      run_q   <= 1'b0;
      code_q  <= 3'd0;
    end else begin
      state   <= state_nxt;
      hold    <= hold_nxt;
      pause_q <= (state_nxt inside {IDLE, PAUSED, DONE});
      clear_q <= (state_nxt == CLEAR);
      run_q   <= (state_nxt == RUN);
      code_q  <= state_nxt;
    end
  end

  assign bus.timer_pause   = pause_q;
  assign bus.timer_clear   = clear_q;
  assign bus.timer_running = run_q;
  assign bus.ctrl_state    = code_q;

  // Counters give pause priority over clear, so both must never be requested
  a_pause_clear_excl : assert property (@(posedge sys_clk) !(pause_q && clear_q));

endmodule

// File: tb/tb_timer_ctrl_fsm.sv
// Self-checking bench for timer_ctrl_fsm: table-driven button scenarios with a
// scoreboard queue, plus hand-written latency, hold, coincidence and reset cases.
module tb_timer_ctrl_fsm;

  localparam int unsigned D = 4;
  localparam int unsigned C = 2;

  typedef enum int {A_NONE, A_SS, A_CLR, A_MAX, A_BSS, A_BCLR} act_t;
  typedef struct {
    act_t       act;
    logic [5:0] exp;
    string      name;
  } step_t;
  typedef struct {
    string      name;
    logic [5:0] exp;
  } sb_t;

  logic sys_clk = 1'b0;
  logic int_reset;
  int   checks   = 0;
  int   failures = 0;
  sb_t  sbq[$];
  step_t tbl[13];

  always #5 sys_clk = ~sys_clk;

  timer_ctrl_if bus ();
  timer_ctrl_if bus2 ();

  timer_ctrl_fsm #(.DEBOUNCE_CYCLES(D), .CLEAR_CYCLES(C)) dut (
    .sys_clk  (sys_clk),
    .int_reset(int_reset),
    .bus      (bus)
  );

  timer_ctrl_fsm #(.DEBOUNCE_CYCLES(1), .CLEAR_CYCLES(15)) dut2 (
    .sys_clk  (sys_clk),
    .int_reset(int_reset),
    .bus      (bus2)
  );

  function automatic logic [5:0] mk(bit p, bit c, bit r, logic [2:0] s);
    return {p, c, r, s};
  endfunction

  function automatic logic [5:0] dut_vec();
    return {bus.timer_pause, bus.timer_clear, bus.timer_running, bus.ctrl_state};
  endfunction

  task automatic check_vec(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got pause/clear/run/state=%b want %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic sb_push(input string name, input logic [5:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sbq.push_back(e);
  endtask

  task automatic sb_check();
    sb_t e;
    if (sbq.size() == 0) begin
      check_int("scoreboard_empty", 0, 1);
    end else begin
      e = sbq.pop_front();
      check_vec(e.name, dut_vec(), e.exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic press(input bit clr, input int hold);
    if (clr) bus.btn_clear = 1'b1;
    else     bus.btn_start_stop = 1'b1;
    settle(hold);
    bus.btn_clear      = 1'b0;
    bus.btn_start_stop = 1'b0;
    settle(4);
  endtask

  task automatic bounce(input bit clr);
    repeat (5) begin
      if (clr) bus.btn_clear = 1'b1;
      else     bus.btn_start_stop = 1'b1;
      settle(3);
      bus.btn_clear      = 1'b0;
      bus.btn_start_stop = 1'b0;
      settle(1);
    end
    settle(4);
  endtask

  task automatic pulse_max();
    bus.timer_max_reached = 1'b1;
    settle(1);
    bus.timer_max_reached = 1'b0;
    settle(2);
  endtask

  task automatic apply(input act_t a);
    case (a)
      A_SS:    press(1'b0, D + 4);
      A_CLR:   press(1'b1, D + 4);
      A_MAX:   pulse_max();
      A_BSS:   bounce(1'b0);
      A_BCLR:  bounce(1'b1);
      default: settle(4);
    endcase
  endtask

  initial begin
    int k;
    int cnt;
    int viol;
    int seen;
    int found;

    tbl[0]  = '{A_SS,   mk(1, 0, 0, 3'd2), "run_to_paused"};
    tbl[1]  = '{A_MAX,  mk(1, 0, 0, 3'd2), "max_ignored_paused"};
    tbl[2]  = '{A_SS,   mk(0, 0, 1, 3'd1), "paused_to_run"};
    tbl[3]  = '{A_BSS,  mk(0, 0, 1, 3'd1), "bounce_ss_run"};
    tbl[4]  = '{A_MAX,  mk(1, 0, 0, 3'd4), "run_to_done"};
    tbl[5]  = '{A_SS,   mk(1, 0, 0, 3'd4), "ss_ignored_done"};
    tbl[6]  = '{A_MAX,  mk(1, 0, 0, 3'd4), "max_in_done"};
    tbl[7]  = '{A_CLR,  mk(1, 0, 0, 3'd0), "done_clear_idle"};
    tbl[8]  = '{A_MAX,  mk(1, 0, 0, 3'd0), "max_ignored_idle"};
    tbl[9]  = '{A_BCLR, mk(1, 0, 0, 3'd0), "bounce_clr_idle"};
    tbl[10] = '{A_SS,   mk(0, 0, 1, 3'd1), "idle_to_run"};
    tbl[11] = '{A_CLR,  mk(1, 0, 0, 3'd0), "run_clear_idle"};
    tbl[12] = '{A_NONE, mk(1, 0, 0, 3'd0), "idle_stays"};

    int_reset              = 1'b1;
    bus.btn_start_stop     = 1'b0;
    bus.btn_clear          = 1'b0;
    bus.timer_max_reached  = 1'b0;
    bus2.btn_start_stop    = 1'b0;
    bus2.btn_clear         = 1'b0;
    bus2.timer_max_reached = 1'b0;
    settle(3);
    sb_push("reset_state", mk(1, 0, 0, 3'd0));
    sb_check();
    int_reset = 1'b0;
    settle(4);

    // Start latency: pause falls exactly D+3 edges after first high sample
    bus.btn_start_stop = 1'b1;
    for (k = 1; k <= int'(D) + 3; k++) begin
      settle(1);
      if (k == int'(D) + 2) check_int("latency_pause_before", int'(bus.timer_pause), 1);
    end
    sb_push("latency_run", mk(0, 0, 1, 3'd1));
    sb_check();
    settle(20);
    sb_push("held_no_second", mk(0, 0, 1, 3'd1));
    sb_check();
    bus.btn_start_stop = 1'b0;
    settle(4);

    for (int i = 0; i < 13; i++) begin
      sb_push(tbl[i].name, tbl[i].exp);
      apply(tbl[i].act);
      sb_check();
    end

    // Coincident start/stop pulse and max reached in RUN: max wins
    press(1'b0, D + 4);
    bus.btn_start_stop = 1'b1;
    settle(D + 2);
    bus.timer_max_reached = 1'b1;
    settle(1);
    bus.timer_max_reached = 1'b0;
    check_vec("coincide_done", dut_vec(), mk(1, 0, 0, 3'd4));
    bus.btn_start_stop = 1'b0;
    settle(4);
    seen = 0;
    bus.btn_clear = 1'b1;
    for (k = 1; k <= 12; k++) begin
      settle(1);
      if (k == int'(D) + 4) bus.btn_clear = 1'b0;
      if (bus.ctrl_state == 3'd3) seen = 1;
    end
    check_int("done_clear_seen", seen, 1);
    check_vec("done_clear_back_idle", dut_vec(), mk(1, 0, 0, 3'd0));

    // Clear from PAUSED: clear held exactly C cycles with pause low
    press(1'b0, D + 4);
    press(1'b0, D + 4);
    check_vec("to_paused", dut_vec(), mk(1, 0, 0, 3'd2));
    cnt  = 0;
    viol = 0;
    bus.btn_clear = 1'b1;
    for (k = 1; k <= 16; k++) begin
      settle(1);
      if (k == int'(D) + 4) bus.btn_clear = 1'b0;
      if (bus.timer_clear) cnt++;
      if (bus.timer_clear && bus.timer_pause) viol++;
    end
    check_int("clear_hold_cycles", cnt, int'(C));
    check_int("pause_during_clear", viol, 0);
    check_vec("clear_to_idle", dut_vec(), mk(1, 0, 0, 3'd0));

    // Second clear pulse during a long hold must not restart it
    cnt = 0;
    bus2.btn_clear = 1'b1;
    for (k = 1; k <= 30; k++) begin
      settle(1);
      if (k == 4)  bus2.btn_clear = 1'b0;
      if (k == 6)  bus2.btn_clear = 1'b1;
      if (k == 10) bus2.btn_clear = 1'b0;
      if (bus2.timer_clear) cnt++;
    end
    check_int("clear_not_extended", cnt, 15);
    check_int("dut2_idle", int'(bus2.ctrl_state), 0);

    // Reset in the middle of a CLEAR hold with both buttons held
    found = 0;
    bus.btn_clear = 1'b1;
    for (k = 0; k < 30 && found == 0; k++) begin
      settle(1);
      if (bus.timer_clear) found = 1;
    end
    check_int("wait_clear", found, 1);
    bus.btn_start_stop = 1'b1;
    int_reset = 1'b1;
    settle(1);
    check_vec("reset_mid_clear", dut_vec(), mk(1, 0, 0, 3'd0));
    int_reset = 1'b0;
    viol = 0;
    for (k = 0; k < 20; k++) begin
      settle(1);
      if (bus.ctrl_state != 3'd0) viol++;
    end
    check_int("held_after_reset_no_pulse", viol, 0);
    bus.btn_start_stop = 1'b0;
    bus.btn_clear      = 1'b0;
    settle(4);
    sb_push("repress_after_reset", mk(0, 0, 1, 3'd1));
    press(1'b0, D + 4);
    sb_check();

    check_int("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
